// File: rtl/i2c_mon_pkg.sv
// i2c_mon_pkg: shared defaults for the I2C line monitor
// Holds the default channel count, synchroniser depth, the line idle level and
// the counter widths used by the filter, hold-off and bus-idle logic.
package i2c_mon_pkg;
    localparam int   NCH_DEF   = 2;
    localparam int   SYNC_DEF  = 2;
    localparam int   FILT_W    = 4;
    localparam int   HOLD_W    = 16;
    localparam int   IDLE_W    = 16;
    localparam logic LINE_IDLE = 1'b1;
endpackage

// File: rtl/i2c_line_monitor_if.sv
// i2c_line_monitor_if: raw lines, runtime timing config and monitor results
// Ports (signals):
//   lin                  raw asynchronous line inputs (ch0 = SCL, ch1 = SDA)
//   filt_len             glitch filter length in cycles (0 behaves as 1)
//   hold_rise/hold_fall  lockout cycles after an accepted rise/fall
//   idle_timeout         bus-free timeout in cycles (0 disables)
//   lvl/lohi/hilo        filtered levels and 1-cycle edge pulses
//   sta/rsta/sto         START, repeated-START and STOP pulses
//   bby/bus_to           bus busy and timeout-clear pulse
// Modports: master drives lines and config, slave is the monitor itself.
interface i2c_line_monitor_if #(
    parameter int NCH    = i2c_mon_pkg::NCH_DEF,
    parameter int FILT_W = i2c_mon_pkg::FILT_W,
    parameter int HOLD_W = i2c_mon_pkg::HOLD_W,
    parameter int IDLE_W = i2c_mon_pkg::IDLE_W
);
    logic [NCH-1:0]    lin;
    logic [FILT_W-1:0] filt_len;
    logic [HOLD_W-1:0] hold_rise;
    logic [HOLD_W-1:0] hold_fall;
    logic [IDLE_W-1:0] idle_timeout;
    logic [NCH-1:0]    lvl;
    logic [NCH-1:0]    lohi;
    logic [NCH-1:0]    hilo;
    logic              sta;
    logic              rsta;
    logic              sto;
    logic              bby;
    logic              bus_to;
    modport master (
        output lin, filt_len, hold_rise, hold_fall, idle_timeout,
        input  lvl, lohi, hilo, sta, rsta, sto, bby, bus_to
    );
    modport slave (
        input  lin, filt_len, hold_rise, hold_fall, idle_timeout,
        output lvl, lohi, hilo, sta, rsta, sto, bby, bus_to
    );
endinterface

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: one-line synchroniser, glitch filter and edge hold-off
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   lin                  raw asynchronous line
//   filt_len             cycles a new level must persist (0 behaves as 1)
//   hold_rise/hold_fall  lockout loaded when a rise/fall is accepted
//   lvl                  filtered level
//   lohi/hilo            1-cycle pulses coincident with the new lvl
module i2c_line_filter
    import i2c_mon_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_DEF,
    parameter int   FILT_W      = i2c_mon_pkg::FILT_W,
    parameter int   HOLD_W      = i2c_mon_pkg::HOLD_W,
    parameter logic RESET_LVL   = LINE_IDLE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lin,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [HOLD_W-1:0] hold_rise,
    input  logic [HOLD_W-1:0] hold_fall,
    output logic              lvl,
    output logic              lohi,
    output logic              hilo
);
    if (SYNC_STAGES < 2) begin : g_sync_chk
        $error("i2c_line_filter: SYNC_STAGES must be >= 2");
    end
    logic [SYNC_STAGES-1:0] sync;
    logic [FILT_W-1:0]      fcnt;
    logic [HOLD_W-1:0]      hold;
    logic [FILT_W:0]        f_eff;
    logic [FILT_W:0]        f_next;
    logic                   s;
    assign s      = sync[SYNC_STAGES-1];
    assign f_eff  = (filt_len == '0) ? (FILT_W+1)'(1) : {1'b0, filt_len};
    assign f_next = {1'b0, fcnt} + (FILT_W+1)'(1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {SYNC_STAGES{RESET_LVL}};
            lvl  <= RESET_LVL;
            lohi <= 1'b0;
            hilo <= 1'b0;
            fcnt <= '0;
            hold <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], lin};
            lohi <= 1'b0;
            hilo <= 1'b0;
            hold <= (hold != '0) ? hold - HOLD_W'(1) : '0;
            if (s == lvl) begin
                fcnt <= '0;
            end else if (hold != '0) begin
                // keep counting during lockout but park at F-1 so the level is
                // accepted on the first hold-free cycle
                fcnt <= (f_next >= f_eff) ? FILT_W'(f_eff - (FILT_W+1)'(1)) : f_next[FILT_W-1:0];
            end else if (f_next >= f_eff) begin
                lvl  <= s;
                lohi <= s;
                hilo <= ~s;
                fcnt <= '0;
                hold <= s ? hold_rise : hold_fall;
            end else begin
                fcnt <= f_next[FILT_W-1:0];
            end
        end
    end
endmodule

// File: rtl/i2c_line_monitor.sv
// i2c_line_monitor: filtered I2C lines plus START/STOP/busy/timeout detection
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       i2c_line_monitor_if.slave: lines and config in, levels,
//             edge pulses and bus conditions out (ch0 = SCL, ch1 = SDA;
//             higher channels are edge-only and do not touch the bus logic)
// Interface parameters must match NCH/FILT_W/HOLD_W/IDLE_W here.
module i2c_line_monitor
    import i2c_mon_pkg::*;
#(
    parameter int             NCH         = NCH_DEF,
    parameter int             SYNC_STAGES = SYNC_DEF,
    parameter int             FILT_W      = i2c_mon_pkg::FILT_W,
    parameter int             HOLD_W      = i2c_mon_pkg::HOLD_W,
    parameter int             IDLE_W      = i2c_mon_pkg::IDLE_W,
    parameter logic [NCH-1:0] RESET_LVL   = {NCH{LINE_IDLE}}
) (
    input logic                clk,
    input logic                rst,
    i2c_line_monitor_if.slave  bus
);
    if (NCH < 2) begin : g_nch_chk
        $error("i2c_line_monitor: NCH must be >= 2");
    end
    logic [NCH-1:0]    lvl;
    logic [NCH-1:0]    lohi;
    logic [NCH-1:0]    hilo;
    logic              scl_d;
    logic              sta_q;
    logic              rsta_q;
    logic              sto_q;
    logic              bby_q;
    logic              bus_to_q;
    logic [IDLE_W-1:0] icnt;
    logic              start;
    logic              stop;
    logic              cnt_en;
    logic              hit;
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        i2c_line_filter #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_W     (FILT_W),
            .HOLD_W     (HOLD_W),
            .RESET_LVL  (RESET_LVL[g])
        ) u_filt (
            .clk      (clk),
            .rst      (rst),
            .lin      (bus.lin[g]),
            .filt_len (bus.filt_len),
            .hold_rise(bus.hold_rise),
            .hold_fall(bus.hold_fall),
            .lvl      (lvl[g]),
            .lohi     (lohi[g]),
            .hilo     (hilo[g])
        );
    end
    // scl_d is SCL as it was before the edge that produced the SDA pulse, so a
    // simultaneous SCL edge cannot mask or fake a bus condition
    assign start  = hilo[1] & scl_d;
    assign stop   = lohi[1] & scl_d;
    assign cnt_en = bby_q & lvl[0] & lvl[1];
    assign hit    = cnt_en && (bus.idle_timeout != '0) && (icnt >= bus.idle_timeout - IDLE_W'(1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_d    <= RESET_LVL[0];
            sta_q    <= 1'b0;
            rsta_q   <= 1'b0;
            sto_q    <= 1'b0;
            bby_q    <= 1'b0;
            bus_to_q <= 1'b0;
            icnt     <= '0;
        end else begin
            scl_d    <= lvl[0];
            sta_q    <= start;
            rsta_q   <= start & bby_q;
            sto_q    <= stop;
            // a START or STOP landing with the timeout takes precedence, so
            // bus_to only reports clears caused purely by idleness
            bus_to_q <= hit & ~start & ~stop;
            bby_q    <= start ? 1'b1 : (stop | hit) ? 1'b0 : bby_q;
            icnt     <= (cnt_en & ~hit & ~start) ? icnt + IDLE_W'(1) : '0;
        end
    end
    assign bus.lvl    = lvl;
    assign bus.lohi   = lohi;
    assign bus.hilo   = hilo;
    assign bus.sta    = sta_q;
    assign bus.rsta   = rsta_q;
    assign bus.sto    = sto_q;
    assign bus.bby    = bby_q;
    assign bus.bus_to = bus_to_q;
endmodule

// File: tb/tb_i2c_line_monitor.sv
// tb_i2c_line_monitor: directed self-checking bench for i2c_line_monitor
module tb_i2c_line_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int n_lohi1 = 0, n_hilo1 = 0, n_sta = 0, n_sto = 0, n_bto = 0, n_pulse = 0;
    int p0, p1, p2;

    i2c_line_monitor_if #(.NCH(2)) bus();
    i2c_line_monitor #(.NCH(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    // pulse tallies sampled 1 time unit after each edge; tick() returns at +2
    always @(posedge clk) begin
        #1;
        n_lohi1 += int'(bus.lohi[1]);
        n_hilo1 += int'(bus.hilo[1]);
        n_sta   += int'(bus.sta);
        n_sto   += int'(bus.sto);
        n_bto   += int'(bus.bus_to);
        n_pulse += int'((|bus.lohi) | (|bus.hilo) | bus.sta | bus.sto | bus.rsta | bus.bus_to);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        bus.lin          = 2'b11;
        bus.filt_len     = 4'd3;
        bus.hold_rise    = '0;
        bus.hold_fall    = '0;
        bus.idle_timeout = '0;
        tick(3);
        chk("rst_lvl", bus.lvl, 2'b11);
        chk("rst_lohi", bus.lohi, 2'b00);
        chk("rst_hilo", bus.hilo, 2'b00);
        chk("rst_bby", bus.bby, 0);
        chk("rst_sta", bus.sta, 0);
        rst = 1'b0;
        tick(6);
        chk("idle_no_pulse", n_pulse, 0);

        // START: SDA falls with SCL high, latency SYNC_STAGES+F = 5
        bus.lin = 2'b01;
        tick(4);
        chk("sda_fall_early", bus.hilo[1], 0);
        chk("sda_lvl_early", bus.lvl[1], 1);
        tick(1);
        chk("sda_fall_pulse", bus.hilo[1], 1);
        chk("sda_fall_lvl", bus.lvl, 2'b01);
        tick(1);
        chk("start_sta", bus.sta, 1);
        chk("start_bby", bus.bby, 1);
        chk("start_rsta", bus.rsta, 0);
        chk("start_hilo_done", bus.hilo[1], 0);
        tick(1);
        chk("start_sta_1cyc", bus.sta, 0);

        // 2-cycle high glitch on SDA is rejected
        p0 = n_lohi1;
        bus.lin = 2'b11;
        tick(2);
        bus.lin = 2'b01;
        tick(8);
        chk("glitch_no_lohi", n_lohi1, p0);
        chk("glitch_lvl", bus.lvl, 2'b01);

        // STOP: SDA rises with SCL high
        bus.lin = 2'b11;
        tick(5);
        chk("sda_rise_pulse", bus.lohi[1], 1);
        tick(1);
        chk("stop_sto", bus.sto, 1);
        chk("stop_bby", bus.bby, 0);
        chk("stop_sta", bus.sta, 0);

        // SDA toggling while SCL low gives no bus conditions
        p0 = n_sta;
        p1 = n_sto;
        bus.lin = 2'b10;
        tick(6);
        bus.lin = 2'b00;
        tick(6);
        bus.lin = 2'b10;
        tick(6);
        chk("scl_low_no_sta", n_sta, p0);
        chk("scl_low_no_sto", n_sto, p1);
        chk("scl_low_lvl", bus.lvl, 2'b10);

        // fall hold-off of 10 swallows SDA chatter
        bus.hold_fall = 16'd10;
        bus.hold_rise = 16'd6;
        p0 = n_hilo1;
        p1 = n_lohi1;
        bus.lin = 2'b00;
        tick(5);
        chk("hold_first_fall", bus.hilo[1], 1);
        bus.lin = 2'b10; tick(2);
        bus.lin = 2'b00; tick(2);
        bus.lin = 2'b10; tick(2);
        bus.lin = 2'b00; tick(2);
        bus.lin = 2'b10;
        tick(4);
        chk("hold_rise_early", bus.lohi[1], 0);
        chk("hold_lvl_low", bus.lvl, 2'b00);
        tick(1);
        chk("hold_rise_pulse", bus.lohi[1], 1);
        chk("hold_one_hilo", n_hilo1, p0 + 1);
        chk("hold_one_lohi", n_lohi1, p1 + 1);

        // fall arriving during the 6-cycle rise hold-off is accepted the
        // first hold-free cycle: 7 edges instead of 5
        bus.lin = 2'b00;
        tick(6);
        chk("hold_rel_early", bus.hilo[1], 0);
        tick(1);
        chk("hold_rel_pulse", bus.hilo[1], 1);

        bus.hold_rise = '0;
        bus.hold_fall = '0;
        bus.lin = 2'b10;
        tick(15);
        bus.lin = 2'b11;
        tick(8);
        chk("idle_again_lvl", bus.lvl, 2'b11);
        chk("idle_again_bby", bus.bby, 0);

        // repeated START while busy
        bus.lin = 2'b01;
        tick(6);
        chk("rs_first_sta", bus.sta, 1);
        chk("rs_first_rsta", bus.rsta, 0);
        bus.lin = 2'b00; tick(6);
        bus.lin = 2'b10; tick(6);
        bus.lin = 2'b11; tick(6);
        bus.lin = 2'b01;
        tick(6);
        chk("rs_sta", bus.sta, 1);
        chk("rs_rsta", bus.rsta, 1);
        chk("rs_bby", bus.bby, 1);

        // bus-free timeout of 20 counting cycles
        bus.idle_timeout = 16'd20;
        bus.lin = 2'b00; tick(6);
        bus.lin = 2'b10; tick(6);
        bus.lin = 2'b11;
        tick(24);
        chk("to_bby_before", bus.bby, 1);
        chk("to_pulse_before", bus.bus_to, 0);
        tick(1);
        chk("to_pulse", bus.bus_to, 1);
        chk("to_bby_clear", bus.bby, 0);
        tick(1);
        chk("to_pulse_1cyc", bus.bus_to, 0);

        // START landing on what would be the timeout cycle
        bus.lin = 2'b01;
        tick(6);
        chk("to2_bby_set", bus.bby, 1);
        bus.lin = 2'b00; tick(6);
        bus.lin = 2'b10; tick(6);
        bus.lin = 2'b11;
        p2 = n_bto;
        tick(19);
        bus.lin = 2'b01;
        tick(5);
        chk("to2_hilo", bus.hilo[1], 1);
        tick(1);
        chk("to2_sta", bus.sta, 1);
        chk("to2_rsta", bus.rsta, 1);
        chk("to2_bby", bus.bby, 1);
        tick(3);
        chk("to2_no_bus_to", n_bto, p2);
        chk("to2_bby_hold", bus.bby, 1);

        // reset mid hold (SCL) and mid filter (SDA)
        bus.hold_fall = 16'd10;
        bus.lin = 2'b00;
        tick(5);
        chk("pre_rst_scl_fall", bus.hilo[0], 1);
        bus.lin = 2'b10;
        tick(3);
        rst = 1'b1;
        #1;
        chk("mid_rst_lvl", bus.lvl, 2'b11);
        chk("mid_rst_lohi", bus.lohi, 2'b00);
        chk("mid_rst_hilo", bus.hilo, 2'b00);
        chk("mid_rst_bby", bus.bby, 0);
        bus.lin = 2'b11;
        tick(3);
        rst = 1'b0;
        p0 = n_pulse;
        tick(10);
        chk("rel_no_pulse", n_pulse, p0);
        chk("rel_lvl", bus.lvl, 2'b11);
        bus.lin = 2'b10;
        tick(4);
        chk("rel_edge_early", bus.hilo[0], 0);
        tick(1);
        chk("rel_edge_pulse", bus.hilo[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_line_monitor.md
Name: i2c_line_monitor

Overview:
- Parametrised successor to the single-line I2C edge detector.
- Each of NCH open-drain lines passes through a synchroniser and a runtime-programmable glitch filter, then separate rise/fall hold-off counters.
- Outputs per channel: filtered level, lohi pulse, hilo pulse.
- Channel 0 is SCL and channel 1 is SDA. From them the block derives START, STOP, repeated-START, bus busy and a bus-free timeout. It feeds the master and slave FSMs.

Parameters:
- NCH, 2, number of lines; must be >=2 (elaboration error otherwise); ch0=SCL, ch1=SDA, others edge-only (e.g. SMBALERT).
- SYNC_STAGES, 2, synchroniser depth; must be >=2.
- FILT_W, 4, width of filter length and filter counters.
- HOLD_W, 16, width of hold-off values and counters.
- IDLE_W, 16, width of idle timeout and idle counter.
- RESET_LVL, all ones, reset value of the synchroniser flops and lvl (I2C idle high).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- lin  in  NCH  raw asynchronous line inputs.
- filt_len  in  FILT_W  cycles a new level must be stable before acceptance; 0 treated as 1.
- hold_rise  in  HOLD_W  lockout cycles after an accepted rise.
- hold_fall  in  HOLD_W  lockout cycles after an accepted fall.
- idle_timeout  in  IDLE_W  bus-free timeout in cycles; 0 disables.
- lvl  out  NCH  filtered levels.
- lohi  out  NCH  1-cycle pulse on an accepted 0->1.
- hilo  out  NCH  1-cycle pulse on an accepted 1->0.
- sta  out  1  START pulse.
- rsta  out  1  repeated-START pulse.
- sto  out  1  STOP pulse.
- bby  out  1  bus busy.
- bus_to  out  1  pulse when busy is cleared by timeout.

Behaviour:
- Reset is asynchronous, active-high (rst); clock is clk.
- Reset values: sync flops and lvl = RESET_LVL; lohi, hilo, sta, rsta, sto, bby, bus_to = 0; all counters = 0.
- Synchroniser: SYNC_STAGES flops per channel; s[i] = last stage.
- Filter, per channel, effective length F = max(filt_len, 1):
  - If s == lvl: fcnt <= 0.
  - Else if hold counter != 0: fcnt saturates at F-1.
  - Else if fcnt+1 >= F: lvl <= s; pulse lohi or hilo; fcnt <= 0; hold <= hold_rise or hold_fall (value sampled on that edge).
  - Else: fcnt++.
- Glitches shorter than F cycles at s produce no pulse and no lvl change.
- Latency: a clean input change shows on lvl and on the edge pulse exactly SYNC_STAGES+F clock edges later. The pulse is coincident with the new lvl value.
- Hold-off: the counter decrements each cycle to 0. A level differing throughout hold-off is accepted on the first cycle with hold==0 if fcnt reached F-1. hold=0 means no lockout.
- filt_len changed mid-count: the comparison uses the current value. If fcnt >= new F-1 and s != lvl, accept on the next hold-free cycle.
- Bus conditions are registered one cycle after the SDA edge pulse and qualified with the SCL lvl value from before that clock edge:
  - sta = hilo[1] & scl_old.
  - sto = lohi[1] & scl_old.
  - rsta = sta & bby(old).
  - Simultaneous SCL and SDA edges use the old SCL level.
- bby: set on sta; cleared on sto or on timeout.
- Idle counter:
  - Counts while bby & lvl[0] & lvl[1]; otherwise clears.
  - When it reaches idle_timeout (nonzero): bby <= 0, bus_to pulses 1 cycle, counter clears.
  - sta in the same cycle as the timeout: sta wins; bby stays 1; rsta=1; no bus_to; counter clears.
  - sto and timeout in the same cycle: single bby clear; bus_to not asserted.
- sta and sto are mutually exclusive by construction (single SDA edge per cycle).
- Channels >=2 do not affect the bus logic.
- Reset mid-operation: every register returns to its reset value immediately; no pulse is emitted on release. The first edge requires a full synchroniser+filter delay.

Decomposition:
- Shared package i2c_mon_pkg: RESET_LVL default and width constants FILT_W, HOLD_W, IDLE_W.
- Sub-module i2c_line_filter: one channel containing the synchroniser, filter counter, hold counter and pulse outputs; generate-instantiated NCH times.
- Bus-condition and idle logic stay in i2c_line_monitor.
- The timing-parameter include supplies default hold values to the integrating level only.

Test Plan:
- filt_len=3, SYNC_STAGES=2, hold=0; lin[1] 1->0 held -> hilo[1] pulses exactly 5 edges later with lvl[1]=0; a 2-cycle low glitch gives no pulse.
- hold_fall=10; SDA falls, then toggles 1 and back every 2 cycles for 8 cycles -> exactly one hilo, no lohi; SDA held high after hold expiry -> lohi once lock and filter are satisfied.
- SCL high, SDA falls -> sta=1 and bby=1 one cycle after hilo[1]; SDA rises with SCL high -> sto=1, bby=0; SDA toggles with SCL low -> no sta or sto.
- While bby: second START -> sta=1 and rsta=1 on the same cycle.
- idle_timeout=20, bby=1, both lines high -> bus_to pulses after 20 cycles, bby=0. Same setup with START arriving on cycle 20 -> bby stays 1, rsta=1, no bus_to.
- rst asserted mid filter count and mid hold -> lvl=all ones, all pulses 0 immediately; release with lin=all ones -> no pulses.
